// File: rtl/ex_mem_skid_stage.sv
// ex_mem_skid_stage: EX/MEM pipeline register with a two-entry skid buffer, flush and a saturating stall counter
module ex_mem_skid_stage #(
  parameter int                CTRL_W     = 10,
  parameter int                DATA_W     = 160,
  parameter logic [CTRL_W-1:0] CLEAR_MASK = 10'b00_1011_1100,
  parameter int                CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic              m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d, s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              accept, emit;
  assign in_ready  = reset & ~s_valid_q;
  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q & (m_valid_q ? {CTRL_W{1'b1}} : ~CLEAR_MASK);
  assign out_data  = m_data_q;
  assign stall_cnt = stall_q;
  assign accept    = in_valid & in_ready;
  assign emit      = m_valid_q & out_ready;
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    stall_d   = (m_valid_q & ~out_ready & ~&stall_q) ? stall_q + CNT_W'(1) : stall_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (emit) begin
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
    end else if (m_valid_q) begin
      if (accept && !emit) begin
        s_ctrl_d  = in_ctrl;
        s_data_d  = in_data;
        s_valid_d = 1'b1;
      end else if (accept && emit) begin
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
      end else if (emit) begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      m_ctrl_d  = in_ctrl;
      m_data_d  = in_data;
      m_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
      stall_q   <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
      stall_q   <= stall_d;
    end
  end
endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// tb_ex_mem_skid_stage: randomized bench against a queue-based reference model of the skid stage
module tb_ex_mem_skid_stage;
  localparam int CW = 10, DW = 160;
  localparam logic [CW-1:0] MASK = 10'b00_1011_1100;
  logic clock = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, in_ready2, out_valid2;
  logic [CW-1:0] out_ctrl, out_ctrl2;
  logic [DW-1:0] out_data, out_data2;
  logic [15:0] stall_cnt;
  logic [3:0] stall_cnt2;
  int n_cmp = 0, n_bad = 0;
  logic [CW+DW-1:0] q[$];
  logic [CW+DW-1:0] hd = '0;
  logic [15:0] c16 = '0;
  logic [3:0] c4 = '0;
  logic [CW-1:0] exp_ctrl;
  logic exp_rdy;
  ex_mem_skid_stage dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );
  ex_mem_skid_stage #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_ctrl(out_ctrl2), .out_data(out_data2), .stall_cnt(stall_cnt2)
  );
  always #5 clock = ~clock;
  task automatic tick();
    bit em, ac;
    @(posedge clock);
    if (!reset) begin
      q.delete(); hd = '0; c16 = '0; c4 = '0;
    end else begin
      em = q.size() > 0 && out_ready;
      ac = in_valid && q.size() < 2;
      if (q.size() > 0 && !out_ready) begin
        if (c16 != 16'hFFFF) c16 = c16 + 16'd1;
        if (c4 != 4'hF) c4 = c4 + 4'd1;
      end
      if (flush) q.delete();
      else begin
        if (em) void'(q.pop_front());
        if (ac) q.push_back({in_ctrl, in_data});
      end
      if (q.size() > 0) hd = q[0];
    end
    @(negedge clock);
    exp_ctrl = hd[CW+DW-1:DW] & ((q.size() > 0) ? {CW{1'b1}} : ~MASK);
    exp_rdy  = reset && q.size() < 2;
  endtask
  task automatic drive(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    in_valid = v; in_ctrl = c; in_data = d;
  endtask
  task automatic test_reset();
    reset = 0; drive(1, 10'h3FF, 160'h55);
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready got %0b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (out_ctrl !== '0) begin n_bad++; $display("FAIL rst_out_ctrl got %h want 0", out_ctrl); end
    n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data got %h want 0", out_data); end
    n_cmp++; if (stall_cnt !== '0) begin n_bad++; $display("FAIL rst_stall got %0d want 0", stall_cnt); end
    reset = 1; drive(0, '0, '0);
    tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rel_in_ready got %0b want 1", in_ready); end
  endtask
  task automatic test_stream();
    out_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      drive(1, 10'h3FF, DW'(i));
      tick();
      n_cmp++; if (out_valid !== 1'b1 || out_data !== DW'(i)) begin n_bad++; $display("FAIL stream_%0d got v=%0b d=%0h want v=1 d=%0h", i, out_valid, out_data, i); end
      n_cmp++; if (out_ctrl !== 10'h3FF) begin n_bad++; $display("FAIL stream_ctrl_%0d got %h want 3ff", i, out_ctrl); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_rdy_%0d got %0b want 1", i, in_ready); end
    end
    drive(0, '0, '0);
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drain got %0b want 0", out_valid); end
  endtask
  task automatic test_skid();
    logic [15:0] s0;
    out_ready = 0; s0 = stall_cnt;
    drive(1, 10'h3FF, 160'hA);
    tick();
    n_cmp++; if (out_data !== 160'hA || in_ready !== 1'b1 || stall_cnt !== s0) begin n_bad++; $display("FAIL skid_one got d=%0h r=%0b s=%0d want d=a r=1 s=%0d", out_data, in_ready, stall_cnt, s0); end
    drive(1, 10'h155, 160'hB);
    tick();
    n_cmp++; if (out_data !== 160'hA || in_ready !== 1'b0 || stall_cnt !== s0 + 16'd1) begin n_bad++; $display("FAIL skid_full got d=%0h r=%0b s=%0d want d=a r=0 s=%0d", out_data, in_ready, stall_cnt, s0 + 1); end
    drive(1, 10'h0F0, 160'hC);
    tick();
    n_cmp++; if (stall_cnt !== s0 + 16'd2 || out_data !== 160'hA) begin n_bad++; $display("FAIL skid_hold got s=%0d d=%0h want s=%0d d=a", stall_cnt, out_data, s0 + 2); end
    drive(0, '0, '0); out_ready = 1;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 160'hB || out_ctrl !== 10'h155 || in_ready !== 1'b1) begin n_bad++; $display("FAIL skid_resume got v=%0b d=%0h c=%h r=%0b want v=1 d=b c=155 r=1", out_valid, out_data, out_ctrl, in_ready); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL skid_empty got %0b want 0", out_valid); end
  endtask
  task automatic test_flush();
    out_ready = 0;
    drive(1, 10'h3FF, 160'hA1); tick();
    drive(1, 10'h3FF, 160'hB1); tick();
    flush = 1; drive(1, 10'h3FF, 160'hC1);
    tick();
    flush = 0; drive(0, '0, '0);
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_state got v=%0b r=%0b want v=0 r=1", out_valid, in_ready); end
    n_cmp++; if ((out_ctrl & MASK) !== '0) begin n_bad++; $display("FAIL flush_masked got %h want 0", out_ctrl & MASK); end
    n_cmp++; if (out_ctrl !== 10'h343) begin n_bad++; $display("FAIL flush_mask_val got %h want 343", out_ctrl); end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_ghost_%0d got v=%0b d=%0h want v=0", i, out_valid, out_data); end
    end
    drive(1, 10'h001, 160'hD1); tick();
    flush = 1; drive(0, '0, '0); tick(); flush = 0;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 160'hD1) begin n_bad++; $display("FAIL flush_emit got v=%0b d=%0h want v=0 d=d1", out_valid, out_data); end
  endtask
  task automatic test_saturation();
    reset = 0; tick(); tick(); reset = 1;
    out_ready = 0; drive(1, 10'h3FF, 160'hE); tick(); drive(0, '0, '0);
    for (int i = 0; i < 20; i++) tick();
    n_cmp++; if (stall_cnt2 !== 4'd15) begin n_bad++; $display("FAIL sat_cnt4 got %0d want 15", stall_cnt2); end
    n_cmp++; if (stall_cnt !== 16'd20) begin n_bad++; $display("FAIL sat_cnt16 got %0d want 20", stall_cnt); end
    flush = 1; tick(); flush = 0; tick();
    n_cmp++; if (stall_cnt2 !== 4'd15) begin n_bad++; $display("FAIL sat_flush got %0d want 15", stall_cnt2); end
    reset = 0; tick(); reset = 1;
    n_cmp++; if (stall_cnt2 !== 4'd0 || stall_cnt !== 16'd0) begin n_bad++; $display("FAIL sat_reset got %0d/%0d want 0/0", stall_cnt2, stall_cnt); end
  endtask
  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), CW'($urandom), {$urandom, $urandom, $urandom, $urandom, $urandom});
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush = 1'($urandom_range(0, 19) == 0);
      reset = $urandom_range(0, 79) != 0;
      tick();
      n_cmp++;
      if (out_valid !== (q.size() > 0) || in_ready !== exp_rdy || out_ctrl !== exp_ctrl || out_data !== hd[DW-1:0] || stall_cnt !== c16 || stall_cnt2 !== c4) begin
        n_bad++;
        $display("FAIL rand_%0d got v=%0b r=%0b c=%h d=%h s=%0d/%0d want v=%0b r=%0b c=%h d=%h s=%0d/%0d", i, out_valid, in_ready, out_ctrl, out_data, stall_cnt, stall_cnt2, q.size() > 0, exp_rdy, exp_ctrl, hd[DW-1:0], c16, c4);
      end
    end
  endtask
  initial begin
    @(negedge clock);
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_mem_skid_stage.md
# ex_mem_skid_stage

Parametrised pipeline-stage register that succeeds the fixed-width stage latches between EX/MEM and the other datapath stages. It carries a control field and a payload field as separate, sized buses. A valid/ready handshake with a two-entry skid buffer lets a downstream stall stop the stage without combinational ready paths. A synchronous flush turns both entries into bubbles, and a bubble always presents its masked control bits (branch/jump/write enables) as zero so the PC and register file never act on it.

## Interface
- CTRL_W, default 10, width of control field (LS_bit, Branch, MemtoReg, … packed LSB-first)
- DATA_W, default 160, width of payload field (addresses, ALU result, store data, dest reg)
- CLEAR_MASK, default 10'b00_1011_1100, control bits forced to 0 on out_ctrl whenever out_valid=0
- CNT_W, default 16, width of stall counter
- clock  in  1  rising-edge clock, sole clock domain
- reset  in  1  synchronous, active-low reset
- flush  in  1  synchronous kill of all held entries (branch taken / exception)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle (registered)
- in_ctrl  in  CTRL_W  upstream control field
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head entry
- out_ctrl  out  CTRL_W  head control, masked by CLEAR_MASK when out_valid=0
- out_data  out  DATA_W  head payload
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0

## Operation
- Storage: main entry (m_valid, m_ctrl, m_data) drives outputs; skid entry (s_valid, s_ctrl, s_data).
- Accept = in_valid & in_ready; Emit = out_valid & out_ready.
- in_ready = reset & ~s_valid, a register-derived output with no path from out_ready.
- State from {m_valid, s_valid}: EMPTY (0,0), ONE (1,0), FULL (1,1). The combination (0,1) is illegal and never reached.
- EMPTY:
  - Accept → main loads input → ONE.
  - Otherwise the state holds.
- ONE:
  - Accept and not Emit → skid loads input → FULL.
  - Emit and not Accept → EMPTY.
  - Accept and Emit → main loads input, stays ONE.
  - Neither → hold.
- FULL: in_ready=0.
  - Emit → main loads skid, s_valid clears → ONE.
  - No Emit → hold.
- Order is strictly FIFO. No beat is duplicated or dropped except by flush.
- Data/ctrl registers load only on the transitions above. Otherwise they hold their value, including inside bubbles.
- out_ctrl = m_ctrl & (out_valid ? all-ones : ~CLEAR_MASK). out_data = m_data, unmasked.
- flush=1 (reset high):
  - m_valid and s_valid clear next edge → EMPTY.
  - An input beat offered in the same cycle is discarded even if in_ready=1; upstream treats it as consumed.
  - Data registers are not cleared.
- Priority: reset > flush > handshake transitions.
- stall_cnt increments when out_valid & ~out_ready, saturates at 2^CNT_W−1, and is not affected by flush.

## Timing
- Reset (reset=0 at an edge) drives these values:
  - m_valid=s_valid=0, so out_valid=0.
  - All ctrl/data registers=0, so out_ctrl=0 and out_data=0.
  - stall_cnt=0.
  - in_ready=0 while reset is low, and 1 in the first cycle after reset releases.
- Latency: an accepted beat appears on out_* in the next cycle (1 cycle) when the stage was EMPTY, or when ONE with a simultaneous Emit.
- Throughput: one beat per cycle sustained while out_ready=1.
- Backpressure: in_ready falls in the cycle after the first non-accepted head with a simultaneous Accept. Worst case, one extra beat is absorbed by the skid.
- Resume from FULL: the head is emitted, skid moves to main next edge, and in_ready=1 that same next cycle.
- Flush in FULL or ONE: out_valid=0 and masked out_ctrl bits=0 from the next cycle. in_ready=1 in the next cycle.
- Flush together with Emit: the emitted beat is delivered downstream (the handshake completed) and the stage still empties.
- Reset asserted mid-operation: all entries are lost at that edge, with no partial state.
- stall_cnt at 2^CNT_W−1 with continued stalling: it stays at 2^CNT_W−1.

## Test plan
- Reset/bubble:
  - Hold reset=0 for 2 cycles with in_valid=1 → in_ready=0, out_valid=0, out_ctrl=0, stall_cnt=0.
  - Release → in_ready=1.
- Streaming: out_ready=1, push ctrl 0x3FF/data 1,2,3 on consecutive cycles → out_valid=1 with data 1,2,3 one cycle later each. With default mask, out_ctrl=0x3FF.
- Skid/backpressure:
  - Push A then B with out_ready=0 → FULL, in_ready=0, out_data=A, stall_cnt counts up each stalled cycle.
  - Raise out_ready → A then B emitted in order, in_ready=1 one cycle after A leaves.
- Flush: in FULL, assert flush with in_valid=1 (C) → next cycle out_valid=0, out_ctrl&CLEAR_MASK=0, in_ready=1. C, A and B are never emitted.
- Mask: after flush, m_ctrl holds 0x3FF → out_ctrl=0x3FF&~0x0BC=0x343 while out_valid=0.
- Saturation: CNT_W=4, stall 20 cycles → stall_cnt=15. A subsequent flush leaves it at 15; only reset returns it to 0.
